// File: rtl/rv_wb_pkg.sv
// Shared encodings for the writeback stage: result-source selects, load funct3
// codes, FSM state type and the load legality/alignment check.
package rv_wb_pkg;

  localparam logic [1:0] RD_SEL_ALU = 2'b00;
  localparam logic [1:0] RD_SEL_MEM = 2'b01;
  localparam logic [1:0] RD_SEL_PC4 = 2'b10;
  localparam logic [1:0] RD_SEL_LUI = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  // Encodings that are not legal for the configured XLEN are reported as
  // misaligned so that they never reach the register file.
  function automatic logic load_misaligned(input logic [2:0] f3,
                                           input logic [2:0] off,
                                           input logic       is64);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = off[0];
      F3_LW:         bad = (off[1:0] != 2'b00);
      F3_LWU:        bad = !is64 || (off[1:0] != 2'b00);
      F3_LD:         bad = !is64 || (off != 3'b000);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed lane of the raw memory
// word, then sign- or zero-extends it according to funct3.
module load_align
  import rv_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  raw,
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] byte_off,
  output logic [XLEN-1:0]  data,
  output logic             misalign
);

  logic [XLEN-1:0] lane;

  assign lane = raw >> {byte_off, 3'b000};

  always_comb begin
    data = lane;
    case (funct3)
      F3_LB:   data = XLEN'($signed(lane[7:0]));
      F3_LBU:  data = XLEN'(lane[7:0]);
      F3_LH:   data = XLEN'($signed(lane[15:0]));
      F3_LHU:  data = XLEN'(lane[15:0]);
      F3_LW:   data = XLEN'($signed(lane[31:0]));
      F3_LWU:  data = XLEN'(lane[31:0]);
      default: data = lane;
    endcase
  end

  assign misalign = load_misaligned(funct3, 3'(byte_off), (XLEN == 64));

endmodule

// File: rtl/writeback_pipe.sv
// Registered writeback stage: accepts one retiring instruction per handshake,
// waits for load data when needed and drives the register-file write port.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a new instruction; non-loads write back next cycle
// WAIT_MEM | load captured, waiting for mem_rvalid or the timeout
module writeback_pipe
  import rv_wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RADDR_W      = 5,
  parameter int LOAD_TIMEOUT = 15,
  parameter int OFF_W        = $clog2(XLEN/8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    data_alu_out,
  input  logic [XLEN-1:0]    pc_o,
  input  logic [XLEN-1:0]    lui_imme,
  input  logic [1:0]         rd_select,
  input  logic               load,
  input  logic [2:0]         funct3,
  input  logic [OFF_W-1:0]   byte_off,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               reg_write,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic               mem_rvalid,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]    wb_data,
  output logic               err_misalign,
  output logic               err_timeout,
  output logic               err_spurious
);

  localparam logic [7:0] TMO = 8'(LOAD_TIMEOUT);

  wb_state_t          state;
  logic [7:0]         cnt;
  logic [RADDR_W-1:0] ld_rd;
  logic               ld_rw;
  logic [2:0]         ld_f3;
  logic [OFF_W-1:0]   ld_off;

  logic [XLEN-1:0]    src_data;
  logic [XLEN-1:0]    al_data;
  logic               al_misalign;
  logic               in_misalign;

  assign in_ready = (state == IDLE);

  // Loads are formatted from the captured attributes, not the live inputs,
  // because upstream has moved on by the time mem_rvalid arrives.
  load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_align (
    .raw      (mem_rdata),
    .funct3   (ld_f3),
    .byte_off (ld_off),
    .data     (al_data),
    .misalign (al_misalign)
  );

  assign in_misalign = load_misaligned(funct3, 3'(byte_off), (XLEN == 64));

  // RD_SEL_MEM without load is treated as ALU.
  always_comb begin
    src_data = data_alu_out;
    case (rd_select)
      RD_SEL_PC4: src_data = pc_o + XLEN'(4);
      RD_SEL_LUI: src_data = lui_imme;
      default:    src_data = data_alu_out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ld_rd        <= '0;
      ld_rw        <= 1'b0;
      ld_f3        <= '0;
      ld_off       <= '0;
      wb_en        <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      if (mem_rvalid && state == IDLE)
        err_spurious <= 1'b1;

      case (state)
        IDLE: begin
          if (in_valid) begin
            if (load) begin
              ld_rd  <= rd_addr;
              ld_rw  <= reg_write;
              ld_f3  <= funct3;
              ld_off <= byte_off;
              cnt    <= '0;
              state  <= WAIT_MEM;
              if (in_misalign)
                err_misalign <= 1'b1;
            end else begin
              wb_en   <= reg_write && (rd_addr != '0);
              wb_addr <= rd_addr;
              wb_data <= src_data;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            wb_en   <= ld_rw && (ld_rd != '0) && !al_misalign;
            wb_addr <= ld_rd;
            wb_data <= al_data;
            state   <= IDLE;
          end else if (cnt == TMO) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed self-checking bench for writeback_pipe (XLEN=32, LOAD_TIMEOUT=15).
module tb_writeback_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_alu_out;
  logic [31:0] pc_o;
  logic [31:0] lui_imme;
  logic [1:0]  rd_select;
  logic        load;
  logic [2:0]  funct3;
  logic [1:0]  byte_off;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err_misalign;
  logic        err_timeout;
  logic        err_spurious;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_alu_out (data_alu_out),
    .pc_o         (pc_o),
    .lui_imme     (lui_imme),
    .rd_select    (rd_select),
    .load         (load),
    .funct3       (funct3),
    .byte_off     (byte_off),
    .rd_addr      (rd_addr),
    .reg_write    (reg_write),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 0; load = 0; rd_select = 2'b00; funct3 = 3'b000; byte_off = 2'd0;
    rd_addr = 5'd0; reg_write = 0; mem_rvalid = 0;
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs();
    data_alu_out = 0; pc_o = 0; lui_imme = 0; mem_rdata = 0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if ({wb_en, wb_addr, wb_data} !== 38'd0) begin n_fail++; $display("FAIL reset_wb got en=%b addr=%0d data=%h want zeros", wb_en, wb_addr, wb_data); end
    n_checks++; if ({err_misalign, err_timeout, err_spurious} !== 3'b000) begin n_fail++; $display("FAIL reset_err got %b%b%b want 000", err_misalign, err_timeout, err_spurious); end
    rst = 0;
    tick();
  endtask

  task automatic test_alu;
    in_valid = 1; load = 0; rd_select = 2'b00; data_alu_out = 32'h0000_1234; rd_addr = 5'd5; reg_write = 1;
    tick();
    in_valid = 0;
    n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd5, 32'h0000_1234}) begin n_fail++; $display("FAIL alu_wb got en=%b addr=%0d data=%h want 1/5/00001234", wb_en, wb_addr, wb_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL alu_in_ready got %b want 1", in_ready); end
    tick();
    n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL alu_one_cycle got wb_en=%b want 0", wb_en); end
  endtask

  task automatic test_lb;
    in_valid = 1; load = 1; rd_select = 2'b00; funct3 = 3'b000; byte_off = 2'd2; rd_addr = 5'd7; reg_write = 1;
    data_alu_out = 32'h1111_1111;
    tick();
    in_valid = 0; load = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_ready !== 1'b0 || wb_en !== 1'b0) begin n_fail++; $display("FAIL lb_wait[%0d] got ready=%b en=%b want 0/0", i, in_ready, wb_en); end
      if (i < 2) tick();
    end
    mem_rvalid = 1; mem_rdata = 32'h0080_0000;
    tick();
    mem_rvalid = 0;
    n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd7, 32'hFFFF_FF80}) begin n_fail++; $display("FAIL lb_wb got en=%b addr=%0d data=%h want 1/7/ffffff80", wb_en, wb_addr, wb_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lb_back_idle got %b want 1", in_ready); end
  endtask

  task automatic test_lhu_and_sources;
    in_valid = 1; load = 1; rd_select = 2'b10; funct3 = 3'b101; byte_off = 2'd2; rd_addr = 5'd8; reg_write = 1;
    tick();
    in_valid = 0; load = 0;
    mem_rvalid = 1; mem_rdata = 32'h8001_0000;
    tick();
    mem_rvalid = 0;
    n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd8, 32'h0000_8001}) begin n_fail++; $display("FAIL lhu_wb got en=%b addr=%0d data=%h want 1/8/00008001", wb_en, wb_addr, wb_data); end
    // back-to-back: accept in the cycle the load writes back
    in_valid = 1; rd_select = 2'b10; pc_o = 32'hFFFF_FFFC; rd_addr = 5'd1;
    tick();
    n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd1, 32'h0000_0000}) begin n_fail++; $display("FAIL pc4_wrap got en=%b addr=%0d data=%h want 1/1/00000000", wb_en, wb_addr, wb_data); end
    rd_select = 2'b11; lui_imme = 32'hABCD_E000; rd_addr = 5'd2;
    tick();
    n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd2, 32'hABCD_E000}) begin n_fail++; $display("FAIL lui got en=%b addr=%0d data=%h want 1/2/abcde000", wb_en, wb_addr, wb_data); end
    rd_select = 2'b01; data_alu_out = 32'h0000_0042; mem_rdata = 32'h9999_9999; rd_addr = 5'd3;
    tick();
    in_valid = 0;
    n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd3, 32'h0000_0042}) begin n_fail++; $display("FAIL sel01_alu got en=%b addr=%0d data=%h want 1/3/00000042", wb_en, wb_addr, wb_data); end
  endtask

  task automatic test_misalign_x0;
    in_valid = 1; load = 1; funct3 = 3'b010; byte_off = 2'd1; rd_addr = 5'd9; reg_write = 1;
    tick();
    in_valid = 0; load = 0;
    n_checks++; if (err_misalign !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL misalign_flag got err=%b ready=%b want 1/0", err_misalign, in_ready); end
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 0;
    n_checks++; if (wb_en !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL misalign_nowrite got en=%b ready=%b want 0/1", wb_en, in_ready); end
    in_valid = 1; rd_select = 2'b00; data_alu_out = 32'h0000_0055; rd_addr = 5'd0; reg_write = 1;
    tick();
    n_checks++; if (wb_en !== 1'b0 || wb_data !== 32'h0000_0055) begin n_fail++; $display("FAIL x0_suppress got en=%b data=%h want 0/00000055", wb_en, wb_data); end
    data_alu_out = 32'h0000_0066; rd_addr = 5'd4; reg_write = 0;
    tick();
    in_valid = 0;
    n_checks++; if (wb_en !== 1'b0 || wb_addr !== 5'd4) begin n_fail++; $display("FAIL no_regwrite got en=%b addr=%0d want 0/4", wb_en, wb_addr); end
  endtask

  task automatic test_timeout;
    // mem_rvalid exactly in the timeout cycle completes normally
    in_valid = 1; load = 1; funct3 = 3'b010; byte_off = 2'd0; rd_addr = 5'd10; reg_write = 1;
    tick();
    in_valid = 0; load = 0;
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_waiting got ready=%b want 0", in_ready); end
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 0;
    n_checks++; if ({wb_en, wb_data, err_timeout} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin n_fail++; $display("FAIL tmo_edge_win got en=%b data=%h tmo=%b want 1/deadbeef/0", wb_en, wb_data, err_timeout); end
    // no response at all
    in_valid = 1; load = 1; rd_addr = 5'd11;
    tick();
    in_valid = 0; load = 0;
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (in_ready !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_pending got ready=%b tmo=%b want 0/0", in_ready, err_timeout); end
    tick();
    n_checks++; if ({err_timeout, in_ready, wb_en} !== 3'b110) begin n_fail++; $display("FAIL tmo_abort got tmo=%b ready=%b en=%b want 1/1/0", err_timeout, in_ready, wb_en); end
    n_checks++; if (wb_addr !== 5'd10 || wb_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tmo_wb_hold got addr=%0d data=%h want 10/deadbeef", wb_addr, wb_data); end
  endtask

  task automatic test_reset_midload_spurious;
    in_valid = 1; load = 1; funct3 = 3'b000; byte_off = 2'd0; rd_addr = 5'd12; reg_write = 1;
    tick();
    in_valid = 0; load = 0;
    tick();
    #2 rst = 1;
    #1;
    n_checks++; if ({in_ready, wb_en, wb_addr, wb_data} !== {1'b1, 38'd0}) begin n_fail++; $display("FAIL rst_mid got ready=%b en=%b addr=%0d data=%h want 1/0/0/0", in_ready, wb_en, wb_addr, wb_data); end
    n_checks++; if ({err_misalign, err_timeout, err_spurious} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_err got %b%b%b want 000", err_misalign, err_timeout, err_spurious); end
    tick();
    rst = 0;
    tick();
    mem_rvalid = 1; mem_rdata = 32'h0000_00AA;
    tick();
    mem_rvalid = 0;
    n_checks++; if ({err_spurious, wb_en, in_ready} !== 3'b101) begin n_fail++; $display("FAIL spurious got sp=%b en=%b ready=%b want 1/0/1", err_spurious, wb_en, in_ready); end
    // rvalid coinciding with a load accept is ignored; the load keeps waiting
    in_valid = 1; load = 1; funct3 = 3'b100; byte_off = 2'd1; rd_addr = 5'd13; mem_rvalid = 1; mem_rdata = 32'h0000_AB00;
    tick();
    in_valid = 0; load = 0; mem_rvalid = 0;
    n_checks++; if (in_ready !== 1'b0 || wb_en !== 1'b0) begin n_fail++; $display("FAIL spurious_accept got ready=%b en=%b want 0/0", in_ready, wb_en); end
    mem_rvalid = 1; mem_rdata = 32'h0000_C300;
    tick();
    mem_rvalid = 0;
    n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd13, 32'h0000_00C3}) begin n_fail++; $display("FAIL lbu_after_spurious got en=%b addr=%0d data=%h want 1/13/000000c3", wb_en, wb_addr, wb_data); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lhu_and_sources();
    test_misalign_x0();
    test_timeout();
    test_reset_midload_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
